refresh_scheduler: RTL

REFRESH_SCHEDULER -- requirements
Module: refresh_scheduler

---
 rtl/gc_ref_pkg.sv | 25 ++
 rtl/refresh_scheduler_if.sv | 23 ++
 rtl/ref_interval_timer.sv | 30 +++
 rtl/refresh_scheduler.sv | 133 +++++++++++++
 4 files changed

// File: rtl/gc_ref_pkg.sv
// rtl/gc_ref_pkg.sv - shared types and bank-select helpers for the refresh scheduler
package gc_ref_pkg;

    localparam int MAX_BANKS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        REFRESH,
        ADVANCE
    } ref_state_t;

    function automatic logic [MAX_BANKS-1:0] bank_onehot(input int idx);
        logic [MAX_BANKS-1:0] v;
        v = '0;
        v[idx[$clog2(MAX_BANKS)-1:0]] = 1'b1;
        return v;
    endfunction

    // The COI source for a bank is always its predecessor in the ring.
    function automatic int src_bank(input int cur, input int n);
        return (cur == 0) ? n - 1 : cur - 1;
    endfunction

endpackage

// File: rtl/refresh_scheduler_if.sv
// rtl/refresh_scheduler_if.sv - scheduler to memory-wrapper bank control bundle
interface refresh_scheduler_if #(
    parameter int NUM_BANKS = 4
);
    logic [NUM_BANKS-1:0] start_sr;
    logic [NUM_BANKS-1:0] ref_en_current;
    logic [NUM_BANKS-1:0] ref_en_old;
    logic [NUM_BANKS-1:0] ref_done;

    modport master (
        output start_sr,
        output ref_en_current,
        output ref_en_old,
        input  ref_done
    );

    modport slave (
        input  start_sr,
        input  ref_en_current,
        input  ref_en_old,
        output ref_done
    );
endinterface

// File: rtl/ref_interval_timer.sv
// rtl/ref_interval_timer.sv - free-running sweep interval counter with one-cycle expire pulse
module ref_interval_timer #(
    parameter int REF_INTERVAL = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic expire
);

    localparam int CW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REF_INTERVAL - 1);

    logic [CW-1:0] interval_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            interval_cnt <= '0;
        end else if (!enable) begin
            interval_cnt <= '0;
        end else if (interval_cnt == CNT_LAST) begin
            interval_cnt <= '0;
        end else begin
            interval_cnt <= interval_cnt + CW'(1);
        end
    end

    assign expire = enable && (interval_cnt == CNT_LAST);

endmodule

// File: rtl/refresh_scheduler.sv
// rtl/refresh_scheduler.sv - sequences refresh sweeps across memory banks; REF_WATCHDOG_EN adds a per-bank timeout and ref_err
module refresh_scheduler
    import gc_ref_pkg::*;
#(
    parameter int NUM_BANKS      = 4,
    parameter int REF_INTERVAL   = 1024,
    parameter int MAX_REF_CYCLES = 300
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    refresh_scheduler_if.master          bank_if,
    output logic [$clog2(NUM_BANKS)-1:0] cur_bank,
    output logic                         busy,
    output logic                         sweep_done
`ifdef REF_WATCHDOG_EN
    ,
    output logic                         ref_err
`endif
);

    localparam int BW = $clog2(NUM_BANKS);
    localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS - 1);

    ref_state_t state;
    logic       expire;
    logic       done_hit;
    logic       wd_trip;

    function automatic logic [NUM_BANKS-1:0] bank_sel(input int idx);
        logic [MAX_BANKS-1:0] w;
        w = bank_onehot(idx);
        return w[NUM_BANKS-1:0];
    endfunction

    ref_interval_timer #(
        .REF_INTERVAL(REF_INTERVAL)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .expire (expire)
    );

    // Only the target bank's done matters; other banks' lines are ignored.
    assign done_hit = bank_if.ref_done[cur_bank];

`ifdef REF_WATCHDOG_EN
    localparam int WW = $clog2(MAX_REF_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(MAX_REF_CYCLES - 1);

    logic [WW-1:0] wd_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state == REFRESH) begin
            wd_cnt <= wd_cnt + WW'(1);
        end else begin
            wd_cnt <= '0;
        end
    end

    assign wd_trip = (wd_cnt == WD_LAST);
`else
    assign wd_trip = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                  <= IDLE;
            cur_bank               <= '0;
            busy                   <= 1'b0;
            sweep_done             <= 1'b0;
            bank_if.start_sr       <= '0;
            bank_if.ref_en_current <= '0;
            bank_if.ref_en_old     <= '0;
`ifdef REF_WATCHDOG_EN
            ref_err                <= 1'b0;
`endif
        end else begin
            bank_if.start_sr <= '0;
            sweep_done       <= 1'b0;
`ifdef REF_WATCHDOG_EN
            ref_err          <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    // Expiries seen outside IDLE are simply dropped.
                    if (expire) begin
                        state                  <= START;
                        cur_bank               <= '0;
                        busy                   <= 1'b1;
                        bank_if.start_sr       <= bank_sel(0);
                        bank_if.ref_en_current <= bank_sel(0);
                    end
                end
                START: begin
                    // ref_done here may be stale from the previous pass; never sampled.
                    state              <= REFRESH;
                    bank_if.ref_en_old <= bank_sel(src_bank(int'(cur_bank), NUM_BANKS));
                end
                REFRESH: begin
                    if (done_hit || wd_trip) begin
                        state                  <= ADVANCE;
                        bank_if.ref_en_current <= '0;
                        bank_if.ref_en_old     <= '0;
                        sweep_done             <= (cur_bank == LAST_BANK);
`ifdef REF_WATCHDOG_EN
                        ref_err                <= !done_hit;
`endif
                    end
                end
                ADVANCE: begin
                    if (cur_bank == LAST_BANK) begin
                        state    <= IDLE;
                        cur_bank <= '0;
                        busy     <= 1'b0;
                    end else begin
                        state                  <= START;
                        cur_bank               <= cur_bank + BW'(1);
                        bank_if.start_sr       <= bank_sel(int'(cur_bank) + 1);
                        bank_if.ref_en_current <= bank_sel(int'(cur_bank) + 1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
